// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter unit: FSM encoding and
// the default meaning of each event channel.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FROZEN = 2'b10
  } perf_state_e;

  localparam int EVT_COMMIT = 0;
  localparam int EVT_IREQ   = 1;
  localparam int EVT_IHIT   = 2;
  localparam int EVT_DREQ   = 3;
  localparam int EVT_DHIT   = 4;

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter with a sticky overflow flag; saturates at all-ones or
// wraps to zero depending on SAT_MODE.
module perf_counter_cell #(
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (en && inc) begin
      // Increment from all-ones: flag it, then either hold or roll over.
      if (&cnt) begin
        ovf <= 1'b1;
        if (SAT_MODE == 0) cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_event_counters.sv
// Performance-counter unit: run/freeze FSM, one counter per event strobe
// plus a run-cycle counter, and a registered one-cycle-latency read port.
module perf_event_counters
  import perf_pkg::*;
#(
  parameter int  NUM_EVT  = 5,
  parameter int  CNT_W    = 32,
  parameter int  SAT_MODE = 1,
  localparam int SEL_W    = $clog2(NUM_EVT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  input  logic               clr,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               rd_req,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic               rd_valid,
  output logic [CNT_W-1:0]   rd_data,
  output logic               rd_err,
  output logic [NUM_EVT:0]   ovf,
  output logic               running,
  output logic               frozen
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_EVT);

  perf_state_e      state_q;
  perf_state_e      state_d;
  logic             run_en;
  logic [CNT_W-1:0] cnt_arr [NUM_EVT+1];
  logic [CNT_W-1:0] sel_val;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (halt)  state_d = FROZEN;
        FROZEN:  state_d = FROZEN;
        default: state_d = IDLE;
      endcase
    end
  end

  // running/frozen are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      running <= 1'b0;
      frozen  <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= (state_d == RUN);
      frozen  <= (state_d == FROZEN);
    end
  end

  // Counting is keyed on the current state: the start cycle is skipped,
  // the halt cycle is still counted.
  assign run_en = (state_q == RUN);

  for (genvar i = 0; i <= NUM_EVT; i++) begin : g_cell
    logic inc;
    if (i < NUM_EVT) begin : g_evt
      assign inc = evt[i];
    end else begin : g_cyc
      assign inc = 1'b1;
    end

    perf_counter_cell #(
      .CNT_W    (CNT_W),
      .SAT_MODE (SAT_MODE)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .inc (inc),
      .en  (run_en),
      .clr (clr),
      .cnt (cnt_arr[i]),
      .ovf (ovf[i])
    );
  end

  always_comb begin
    sel_val = '0;
    for (int i = 0; i <= NUM_EVT; i++) begin
      if (rd_sel == SEL_W'(i)) sel_val = cnt_arr[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        if (rd_sel > LAST_SEL) begin
          rd_err  <= 1'b1;
          rd_data <= '0;
        end else begin
          rd_err  <= 1'b0;
          rd_data <= sel_val;
        end
      end else begin
        rd_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_perf_event_counters.sv
// Bench for perf_event_counters: a saturating and a wrapping 4-bit instance
// share stimulus and are checked against an unbounded-count reference model.
module tb_perf_event_counters;

  localparam int NUM_EVT = 5;
  localparam int CNT_W   = 4;
  localparam int SEL_W   = 3;
  localparam int MAX_V   = 15;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               halt = 1'b0;
  logic               clr = 1'b0;
  logic [NUM_EVT-1:0] evt = '0;
  logic               rd_req = 1'b0;
  logic [SEL_W-1:0]   rd_sel = '0;

  logic               s_rd_valid, w_rd_valid;
  logic [CNT_W-1:0]   s_rd_data, w_rd_data;
  logic               s_rd_err, w_rd_err;
  logic [NUM_EVT:0]   s_ovf, w_ovf;
  logic               s_running, w_running;
  logic               s_frozen, w_frozen;

  int checks = 0;
  int errors = 0;

  // {err, wrap_data, sat_data} expected for each issued read
  logic [8:0] exp_q[$];
  int         cnt_m [NUM_EVT+1];
  int         mode_m;            // 0 idle, 1 counting, 2 frozen
  logic [3:0] last_s, last_w;

  perf_event_counters #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .SAT_MODE(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .clr(clr), .evt(evt),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
    .rd_err(s_rd_err), .ovf(s_ovf), .running(s_running), .frozen(s_frozen)
  );

  perf_event_counters #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .SAT_MODE(0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .clr(clr), .evt(evt),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(w_rd_valid), .rd_data(w_rd_data),
    .rd_err(w_rd_err), .ovf(w_ovf), .running(w_running), .frozen(w_frozen)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] sat_val(input int c);
    return (c > MAX_V) ? 4'hF : 4'(c);
  endfunction

  function automatic logic [3:0] wrap_val(input int c);
    return 4'(c % (MAX_V + 1));
  endfunction

  function automatic logic [8:0] model_read(input logic [2:0] sel);
    if (int'(sel) > NUM_EVT) return 9'h100;
    return {1'b0, wrap_val(cnt_m[sel]), sat_val(cnt_m[sel])};
  endfunction

  function automatic logic [NUM_EVT:0] model_ovf();
    logic [NUM_EVT:0] v;
    for (int i = 0; i <= NUM_EVT; i++) v[i] = (cnt_m[i] > MAX_V);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= NUM_EVT; i++) cnt_m[i] = 0;
    mode_m = 0;
  endtask

  task automatic model_update(input logic s, input logic h, input logic c,
                              input logic [NUM_EVT-1:0] e);
    if (c) begin
      model_reset();
    end else if (mode_m == 1) begin
      for (int i = 0; i < NUM_EVT; i++) cnt_m[i] += int'(e[i]);
      cnt_m[NUM_EVT] += 1;
      if (h) mode_m = 2;
    end else if (mode_m == 0 && s) begin
      mode_m = 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per presented read, otherwise checks hold.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      check("valid_agree", 32'(w_rd_valid), 32'(s_rd_valid));
      if (s_rd_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd_valid", 32'(s_rd_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data_sat", 32'(s_rd_data), 32'(e[3:0]));
          check("rd_data_wrap", 32'(w_rd_data), 32'(e[7:4]));
          check("rd_err_sat", 32'(s_rd_err), 32'(e[8]));
          check("rd_err_wrap", 32'(w_rd_err), 32'(e[8]));
          last_s = e[3:0];
          last_w = e[7:4];
        end
      end else begin
        check("rd_data_hold_sat", 32'(s_rd_data), 32'(last_s));
        check("rd_data_hold_wrap", 32'(w_rd_data), 32'(last_w));
        check("rd_err_idle", 32'({s_rd_err, w_rd_err}), 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic s, input logic h, input logic c,
                      input logic [NUM_EVT-1:0] e, input logic r, input logic [2:0] sel);
    @(negedge clk);
    check("running_sat", 32'(s_running), 32'(mode_m == 1));
    check("running_wrap", 32'(w_running), 32'(mode_m == 1));
    check("frozen_sat", 32'(s_frozen), 32'(mode_m == 2));
    check("frozen_wrap", 32'(w_frozen), 32'(mode_m == 2));
    check("ovf_sat", 32'(s_ovf), 32'(model_ovf()));
    check("ovf_wrap", 32'(w_ovf), 32'(model_ovf()));
    start  = s;
    halt   = h;
    clr    = c;
    evt    = e;
    rd_req = r;
    rd_sel = sel;
    if (r) exp_q.push_back(model_read(sel));
    model_update(s, h, c, e);
  endtask

  task automatic cyc(input logic [NUM_EVT-1:0] e);
    step(1'b0, 1'b0, 1'b0, e, 1'b0, 3'd0);
  endtask

  task automatic do_start();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 3'd0);
  endtask

  task automatic do_clr();
    step(1'b0, 1'b0, 1'b1, '0, 1'b0, 3'd0);
  endtask

  task automatic rd(input logic [2:0] sel);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, sel);
  endtask

  task automatic reset_mid_cycle();
    @(posedge clk);
    #2;
    rst = 1'b0;
    start = 1'b0; halt = 1'b0; clr = 1'b0; evt = '0; rd_req = 1'b0; rd_sel = '0;
    exp_q.delete();
    model_reset();
    last_s = '0;
    last_w = '0;
    #1;
    check("rst_rd_valid", 32'({s_rd_valid, w_rd_valid}), 32'd0);
    check("rst_running", 32'({s_running, w_running}), 32'd0);
    check("rst_frozen", 32'({s_frozen, w_frozen}), 32'd0);
    check("rst_ovf", 32'({s_ovf, w_ovf}), 32'd0);
    check("rst_rd_data", 32'({s_rd_data, w_rd_data}), 32'd0);
    #1 rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    last_s = '0;
    last_w = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_valid", 32'({s_rd_valid, w_rd_valid}), 32'd0);
    check("reset_rd_data", 32'({s_rd_data, w_rd_data}), 32'd0);
    check("reset_flags", 32'({s_running, s_frozen, w_running, w_frozen}), 32'd0);
    check("reset_ovf", 32'({s_ovf, w_ovf}), 32'd0);
    rst = 1'b1;

    // Commit count with halt cycle included
    do_start();
    repeat (10) cyc(5'b00001);
    step(1'b0, 1'b1, 1'b0, 5'b00001, 1'b0, 3'd0);
    rd(3'd0);
    @(posedge clk); #1;
    check("plan1_cnt0", 32'(s_rd_data), 32'd11);
    check("plan1_frozen", 32'(s_frozen), 32'd1);
    rd(3'd5);
    @(posedge clk); #1;
    check("plan1_cycles", 32'(s_rd_data), 32'd11);

    // Saturate vs wrap on channel 1
    do_clr();
    do_start();
    repeat (20) cyc(5'b00010);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 3'd0);
    rd(3'd1);
    @(posedge clk); #1;
    check("plan2_sat", 32'(s_rd_data), 32'd15);
    check("plan2_wrap", 32'(w_rd_data), 32'd4);
    check("plan2_ovf", 32'({s_ovf[1], w_ovf[1]}), 32'd3);

    // start ignored while frozen, clear, restart, three all-ones cycles
    do_start();
    do_clr();
    do_start();
    cyc(5'b11111);
    cyc(5'b11111);
    step(1'b0, 1'b1, 1'b0, 5'b11111, 1'b0, 3'd0);
    for (int i = 0; i <= NUM_EVT; i++) rd(3'(i));
    rd(3'd4);
    @(posedge clk); #1;
    check("plan3_cnt4", 32'(s_rd_data), 32'd3);

    // clr beats halt; clr beats start
    do_clr();
    do_start();
    repeat (7) cyc(5'b00100);
    step(1'b0, 1'b1, 1'b1, 5'b00100, 1'b1, 3'd2);
    rd(3'd2);
    step(1'b1, 1'b0, 1'b1, '0, 1'b0, 3'd0);
    cyc('0);
    cyc('0);

    // Back-to-back reads on a live counter, then out-of-range selects
    do_start();
    repeat (8) step(1'b0, 1'b0, 1'b0, 5'b01000, 1'b1, 3'd3);
    rd(3'd6);
    rd(3'd7);
    @(posedge clk); #1;
    check("plan5_err", 32'({s_rd_err, s_rd_data}), 32'h10);

    // Asynchronous reset mid-run with a read in flight
    do_clr();
    do_start();
    repeat (5) cyc(5'($urandom));
    step(1'b0, 1'b0, 1'b0, 5'($urandom), 1'b1, 3'd3);
    reset_mid_cycle();
    for (int i = 0; i <= NUM_EVT; i++) rd(3'(i));

    // Random traffic
    repeat (2000) begin
      step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 99) == 0), 5'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    repeat (3) cyc('0);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_event_counters.md
Name: perf_event_counters

Overview:
Synthesizable, parametrised hardware performance-counter unit that replaces bench-only counting of committed instructions and I/D-cache requests and hits. It takes NUM_EVT single-bit event strobes from the pipeline and a halt strobe from writeback, and keeps one counter per event plus a run-cycle counter. Counting freezes on halt, and any counter can be read back through a one-cycle-latency read port. It sits beside proc under proc_hier and is driven from pipeline and cache status wires.

Parameters:
NUM_EVT, 5, number of event channels (e.g. 0 commit, 1 icache req, 2 icache hit, 3 dcache req, 4 dcache hit).
CNT_W, 32, width of each counter and of rd_data.
SAT_MODE, 1, 1 = counters saturate at all-ones; 0 = counters wrap to zero.
SEL_W (localparam), $clog2(NUM_EVT+1), width of rd_sel.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
start  in  1  pulse; begins counting.
halt  in  1  pulse from writeback; ends counting.
clr  in  1  pulse; zeroes all counters and flags and returns to IDLE.
evt  in  NUM_EVT  per-channel event strobes, sampled every clk.
rd_req  in  1  read request.
rd_sel  in  SEL_W  selects a counter: 0..NUM_EVT-1 are event channels; NUM_EVT is the cycle counter.
rd_valid  out  1  read data valid.
rd_data  out  CNT_W  read data.
rd_err  out  1  rd_sel was out of range.
ovf  out  NUM_EVT+1  sticky overflow flags; bit NUM_EVT is the cycle counter.
running  out  1  state == RUN.
frozen  out  1  state == FROZEN.

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All counters 0, ovf 0, rd_valid 0, rd_data 0, rd_err 0, running 0, frozen 0.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> FROZEN on halt.
  - any state -> IDLE on clr.
- Priority: clr > halt > start.
  - halt is ignored outside RUN.
  - start is ignored in RUN and FROZEN; the unit must be cleared before it can restart.
- Counting in RUN:
  - Each cycle, counter[i] += evt[i]. The cycle counter += 1.
  - The cycle in which halt is sampled is still counted, so its evt bits and cycle increment apply. Counting stops from the next cycle.
  - start-cycle events are not counted; counting begins the cycle after start.
- In IDLE and FROZEN, counters hold.
- clr zeroes every counter and every ovf bit on the same clock edge. Events in the clr cycle are dropped.
- Overflow: an increment from all-ones sets ovf[i] sticky.
  - SAT_MODE=1: the counter stays at all-ones.
  - SAT_MODE=0: the counter wraps to 0.
  - ovf clears only on clr or reset.
- Read port:
  - rd_req sampled at edge N gives rd_valid=1 during cycle N+1.
  - rd_data is the selected counter's value before the edge-N update, i.e. its registered value in cycle N.
  - rd_err=1 and rd_data=0 when rd_sel > NUM_EVT.
  - With no rd_req, rd_valid=0, rd_err=0, and rd_data holds its last value.
  - Back-to-back reads every cycle are supported.
  - Reads are legal in every state, including the clr cycle, where the pre-clear value is returned.
- running and frozen are registered decodes of the state.
- A reset asserted mid-read drops the pending rd_valid.

Decomposition:
- Shared package perf_pkg:
  - state encoding: IDLE=2'b00, RUN=2'b01, FROZEN=2'b10.
  - default channel index constants: EVT_COMMIT, EVT_IREQ, EVT_IHIT, EVT_DREQ, EVT_DHIT.
- One sub-module, perf_counter_cell, instantiated NUM_EVT+1 times (the cycle channel has inc tied to 1):
  - inputs: clk, rst, inc, en, clr.
  - outputs: cnt, ovf.
  - parameters: CNT_W, SAT_MODE.
- The top level holds the FSM and the registered read mux.

Test Plan:
1. Reset, start, then 10 cycles with evt=5'b00001, then halt -> counter0=11 (halt cycle counted), cycle counter=11, frozen=1; reading sel 0 gives rd_data=11 one cycle later.
2. CNT_W=4, SAT_MODE=1, evt[1] held high for 20 RUN cycles -> counter1=15, ovf[1]=1. Repeat with SAT_MODE=0 -> counter1=20 mod 16=4, ovf[1]=1.
3. In FROZEN, pulse start, then clr, then start, then 3 cycles of evt=all-ones -> start is ignored while frozen; after clr all counters=0 and ovf=0; after 3 counted cycles every counter=3.
4. Same-cycle clr and halt in RUN with counter2=7 -> state IDLE, counter2=0. Same-cycle start and clr in IDLE -> state stays IDLE.
5. rd_req every cycle on sel 3 while evt[3] is high -> rd_data sequence increases by 1 per cycle and lags the live count by one. Reading sel 6 with NUM_EVT=5 -> rd_err=1, rd_data=0.
6. Drop rst low asynchronously mid-RUN with rd_req pending -> immediately all counters 0, state IDLE, rd_valid=0, running=0.
